// File: rtl/game_sprite_control_pkg.sv
// game_sprite_control_pkg: screen geometry, coordinate widths and sprite state encoding shared across game blocks.
package game_sprite_control_pkg;
  localparam int X_WIDTH  = 10;
  localparam int Y_WIDTH  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int V_WIDTH  = 4;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} sprite_state_e;
endpackage

// File: rtl/game_rect_hit.sv
// game_rect_hit: combinational point-in-rectangle test on signed coordinates.
module game_rect_hit #(
  parameter int W = 11,
  parameter int H = 11
) (
  input  logic signed [W-1:0] rx_i,
  input  logic signed [H-1:0] ry_i,
  input  logic        [W-1:0] rw_i,
  input  logic        [H-1:0] rh_i,
  input  logic signed [W-1:0] px_i,
  input  logic signed [H-1:0] py_i,
  output logic                hit_o
);
  // One extra bit so origin + size cannot wrap.
  logic signed [W:0] rx_e, rw_e, px_e;
  logic signed [H:0] ry_e, rh_e, py_e;
  assign rx_e = {rx_i[W-1], rx_i};
  assign rw_e = {1'b0, rw_i};
  assign px_e = {px_i[W-1], px_i};
  assign ry_e = {ry_i[H-1], ry_i};
  assign rh_e = {1'b0, rh_i};
  assign py_e = {py_i[H-1], py_i};
  assign hit_o = px_e >= rx_e && px_e < rx_e + rw_e && py_e >= ry_e && py_e < ry_e + rh_e;
endmodule

// File: rtl/game_sprite_control.sv
// game_sprite_control: loads a sprite from the master, steps it autonomously, reports containment and per-pixel hit.
module game_sprite_control
  import game_sprite_control_pkg::*;
#(
  parameter int SPRITE_W    = 8,
  parameter int SPRITE_H    = 8,
  parameter int STEP_PERIOD = 2**20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sprite_write,
  input  logic signed [X_WIDTH:0]   write_x,
  input  logic signed [Y_WIDTH:0]   write_y,
  input  logic signed [V_WIDTH-1:0] write_dx,
  input  logic signed [V_WIDTH-1:0] write_dy,
  input  logic        [X_WIDTH-1:0] pixel_x,
  input  logic        [Y_WIDTH-1:0] pixel_y,
  output logic signed [X_WIDTH:0]   sprite_x,
  output logic signed [Y_WIDTH:0]   sprite_y,
  output logic                      sprite_active,
  output logic                      sprite_within_screen,
  output logic                      sprite_hit
);
  localparam int CW = $clog2(STEP_PERIOD);
  localparam logic signed [X_WIDTH+1:0] X_LIM = (X_WIDTH+2)'(SCREEN_W - SPRITE_W);
  localparam logic signed [Y_WIDTH+1:0] Y_LIM = (Y_WIDTH+2)'(SCREEN_H - SPRITE_H);
  sprite_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [X_WIDTH:0] x_q, x_d;
  logic signed [Y_WIDTH:0] y_q, y_d;
  logic signed [V_WIDTH-1:0] dx_q, dx_d, dy_q, dy_d;
  logic within_q, within_d, hit_q, hit_d, hit_w, active, wrap;
  logic signed [X_WIDTH+1:0] x_e;
  logic signed [Y_WIDTH+1:0] y_e;
  assign active = state_q == ACTIVE;
  assign wrap   = cnt_q == CW'(STEP_PERIOD - 1);
  assign x_e    = {x_q[X_WIDTH], x_q};
  assign y_e    = {y_q[Y_WIDTH], y_q};
  game_rect_hit #(.W(X_WIDTH+1), .H(Y_WIDTH+1)) u_hit (
    .rx_i (x_q),
    .ry_i (y_q),
    .rw_i ((X_WIDTH+1)'(SPRITE_W)),
    .rh_i ((Y_WIDTH+1)'(SPRITE_H)),
    .px_i ({1'b0, pixel_x}),
    .py_i ({1'b0, pixel_y}),
    .hit_o(hit_w)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    within_d = active && !x_e[X_WIDTH+1] && x_e <= X_LIM && !y_e[Y_WIDTH+1] && y_e <= Y_LIM;
    hit_d    = active && hit_w;
    if (sprite_write) begin
      state_d = ACTIVE;
      cnt_d   = '0;
      x_d     = write_x;
      y_d     = write_y;
      dx_d    = write_dx;
      dy_d    = write_dy;
    end else if (active) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      x_d   = wrap ? x_q + {{(X_WIDTH+1-V_WIDTH){dx_q[V_WIDTH-1]}}, dx_q} : x_q;
      y_d   = wrap ? y_q + {{(Y_WIDTH+1-V_WIDTH){dy_q[V_WIDTH-1]}}, dy_q} : y_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      within_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      within_q <= within_d;
      hit_q    <= hit_d;
    end
  end
  assign sprite_x             = x_q;
  assign sprite_y             = y_q;
  assign sprite_active        = active;
  assign sprite_within_screen = within_q;
  assign sprite_hit           = hit_q;
endmodule

// File: tb/tb_game_sprite_control.sv
// tb_game_sprite_control: directed scenarios for load, stepping, containment, hit and reset with STEP_PERIOD=4.
module tb_game_sprite_control;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sprite_write = 1'b0;
  logic signed [10:0] write_x = '0, write_y = '0;
  logic signed [3:0] write_dx = '0, write_dy = '0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic signed [10:0] sprite_x, sprite_y;
  logic sprite_active, sprite_within_screen, sprite_hit;
  int errors = 0;
  int checks = 0;

  game_sprite_control #(.SPRITE_W(8), .SPRITE_H(8), .STEP_PERIOD(4)) dut (
    .clk(clk), .reset_n(reset_n), .sprite_write(sprite_write),
    .write_x(write_x), .write_y(write_y), .write_dx(write_dx), .write_dy(write_dy),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_active(sprite_active),
    .sprite_within_screen(sprite_within_screen), .sprite_hit(sprite_hit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int x, input int y, input int dx, input int dy);
    sprite_write = 1'b1;
    write_x = 11'(x);
    write_y = 11'(y);
    write_dx = 4'(dx);
    write_dy = 4'(dy);
    tick();
    sprite_write = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    tick(100);
    checks++;
    if ({sprite_x, sprite_y, sprite_active, sprite_within_screen, sprite_hit} !== 25'd0) begin
      errors++;
      $display("FAIL reset_idle: x=%0d y=%0d act=%b within=%b hit=%b want all 0", sprite_x, sprite_y, sprite_active, sprite_within_screen, sprite_hit);
    end
    pixel_x = 10'd5;
    pixel_y = 10'd5;
    tick();
    checks++;
    if (sprite_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_hit: got %b want 0", sprite_hit);
    end
  endtask

  task automatic test_step;
    load(100, 50, 2, -1);
    checks++;
    if (sprite_x !== 11'sd100 || sprite_y !== 11'sd50 || sprite_active !== 1'b1) begin
      errors++;
      $display("FAIL load: x=%0d y=%0d act=%b want 100 50 1", sprite_x, sprite_y, sprite_active);
    end
    tick();
    checks++;
    if (sprite_within_screen !== 1'b1) begin
      errors++;
      $display("FAIL within_after_load: got %b want 1", sprite_within_screen);
    end
    tick(2);
    checks++;
    if (sprite_x !== 11'sd100) begin
      errors++;
      $display("FAIL no_early_step: x=%0d want 100", sprite_x);
    end
    tick();
    checks++;
    if (sprite_x !== 11'sd102 || sprite_y !== 11'sd49) begin
      errors++;
      $display("FAIL step1: x=%0d y=%0d want 102 49", sprite_x, sprite_y);
    end
    tick(4);
    checks++;
    if (sprite_x !== 11'sd104 || sprite_y !== 11'sd48) begin
      errors++;
      $display("FAIL step2: x=%0d y=%0d want 104 48", sprite_x, sprite_y);
    end
  endtask

  task automatic test_right_edge;
    load(630, 50, 3, 0);
    tick();
    checks++;
    if (sprite_within_screen !== 1'b1) begin
      errors++;
      $display("FAIL right_in: got %b want 1", sprite_within_screen);
    end
    tick(3);
    checks++;
    if (sprite_x !== 11'sd633 || sprite_within_screen !== 1'b1) begin
      errors++;
      $display("FAIL right_step: x=%0d within=%b want 633 1", sprite_x, sprite_within_screen);
    end
    tick();
    checks++;
    if (sprite_within_screen !== 1'b0) begin
      errors++;
      $display("FAIL right_out: got %b want 0", sprite_within_screen);
    end
  endtask

  task automatic test_left_edge;
    load(-10, 100, 1, 0);
    checks++;
    if (sprite_x !== -11'sd10) begin
      errors++;
      $display("FAIL neg_load: x=%0d want -10", sprite_x);
    end
    tick();
    checks++;
    if (sprite_within_screen !== 1'b0) begin
      errors++;
      $display("FAIL neg_within: got %b want 0", sprite_within_screen);
    end
    tick(38);
    checks++;
    if (sprite_x !== -11'sd1 || sprite_within_screen !== 1'b0) begin
      errors++;
      $display("FAIL neg_minus1: x=%0d within=%b want -1 0", sprite_x, sprite_within_screen);
    end
    tick();
    checks++;
    if (sprite_x !== 11'sd0 || sprite_within_screen !== 1'b0) begin
      errors++;
      $display("FAIL at_zero: x=%0d within=%b want 0 0", sprite_x, sprite_within_screen);
    end
    tick();
    checks++;
    if (sprite_within_screen !== 1'b1) begin
      errors++;
      $display("FAIL zero_within: got %b want 1", sprite_within_screen);
    end
  endtask

  task automatic test_hit;
    int px[6] = '{100, 107, 108, 99, 100, 100};
    int py[6] = '{50, 57, 50, 50, 58, 49};
    logic exp[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    load(100, 50, 0, 0);
    for (int i = 0; i < 6; i++) begin
      pixel_x = 10'(px[i]);
      pixel_y = 10'(py[i]);
      tick();
      checks++;
      if (sprite_hit !== exp[i]) begin
        errors++;
        $display("FAIL hit(%0d,%0d): got %b want %b", px[i], py[i], sprite_hit, exp[i]);
      end
    end
  endtask

  task automatic test_load_wins_and_reset;
    load(200, 100, 5, 5);
    tick(3);
    load(300, 200, 1, 1);
    checks++;
    if (sprite_x !== 11'sd300 || sprite_y !== 11'sd200) begin
      errors++;
      $display("FAIL load_wins: x=%0d y=%0d want 300 200", sprite_x, sprite_y);
    end
    tick(3);
    checks++;
    if (sprite_x !== 11'sd300) begin
      errors++;
      $display("FAIL restart_hold: x=%0d want 300", sprite_x);
    end
    tick();
    checks++;
    if (sprite_x !== 11'sd301 || sprite_y !== 11'sd201) begin
      errors++;
      $display("FAIL restart_step: x=%0d y=%0d want 301 201", sprite_x, sprite_y);
    end
    tick(2);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sprite_x, sprite_y, sprite_active, sprite_within_screen, sprite_hit} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset: x=%0d y=%0d act=%b within=%b hit=%b want all 0", sprite_x, sprite_y, sprite_active, sprite_within_screen, sprite_hit);
    end
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if (sprite_active !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: act=%b want 0", sprite_active);
    end
    load(10, 20, 1, 1);
    checks++;
    if (sprite_x !== 11'sd10 || sprite_y !== 11'sd20 || sprite_active !== 1'b1) begin
      errors++;
      $display("FAIL reload: x=%0d y=%0d act=%b want 10 20 1", sprite_x, sprite_y, sprite_active);
    end
    tick();
    checks++;
    if (sprite_within_screen !== 1'b1) begin
      errors++;
      $display("FAIL reload_within: got %b want 1", sprite_within_screen);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_right_edge();
    test_left_edge();
    test_hit();
    test_load_wins_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
